fp_mul_stage_2: RTL and testbench
=================================

Name: fp_mul_stage_2

Overview:
Second pipeline stage of the floating-point multiplier. It consumes the segmented operands produced by stage 1: sign, hidden-bit mantissas, adjusted exponents, special-case codes and the exponent-infinity flag.
- It resolves the IEEE special-case result, forms the biased exponent sum, and computes the full mantissa product with an iterative radix-2 shift-add multiplier.
- Results go to the normalisation/rounding stage through a valid/ready handshake.

Parameters:
DW, 16, total floating-point width (passed through for consistency; unused internally).
EXP, 5, exponent field width.
MANT, 10, stored mantissa width; operand mantissas are MANT+1 bits including the hidden bit.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  asynchronous active-high reset.
in_valid  in  1  stage-1 outputs are valid.
in_ready  out  1  block can accept an operand pair.
sign_in  in  1  result sign (XOR of the operand signs).
mant_a  in  MANT+1  mantissa A with hidden bit.
mant_b  in  MANT+1  mantissa B with hidden bit.
exp_a  in  EXP  exponent A (denormals already set to 1).
exp_b  in  EXP  exponent B.
spe_case_a  in  3  0 normal, 1 denormal, 2 zero, 3 inf, 4 NaN.
spe_case_b  in  3  same encoding as spe_case_a.
exp_eq_inf_in  in  1  1 when neither exponent is all-ones.
out_valid  out  1  result registers are valid.
out_ready  in  1  downstream accepts the result.
sign_out  out  1  registered result sign.
mant_prod  out  2*MANT+2  unnormalised mantissa product.
exp_sum  out  EXP+2  signed two's-complement exp_a+exp_b-BIAS.
spe_case_out  out  3  result class: 0 compute, 2 zero, 3 inf, 4 NaN.
exp_eq_inf_out  out  1  registered copy of exp_eq_inf_in.

Behaviour:
- Clocking/reset: single clock clk. rst is asynchronous and active-high. While rst is asserted:
  - state=IDLE, counter=0, accumulator=0.
  - All outputs are 0 except in_ready=1.
- BIAS = 2^(EXP-1)-1 (15 at default). exp_sum is computed at accept time, in EXP+2 bits signed, with no saturation. Range at default is -13..45.
- Special-case resolution at accept, in priority order:
  1. Either code is 4, or inf combined with zero (3 with 2, either order) → 4.
  2. Either code is 3 → 3.
  3. Either code is 2 → 2.
  4. Otherwise → 0. Denormal inputs (code 1) take the compute path.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid=1, all inputs are registered. Next state is MUL if the resolved code is 0, else DONE with mant_prod=0.
  - MUL: in_ready=0. Each cycle: acc <= acc + (mb[cnt] ? ma<<cnt : 0), then cnt <= cnt+1. When cnt==MANT, the final partial product is added and the state goes to DONE. MUL takes exactly MANT+1 cycles.
  - DONE: out_valid=1, all outputs held stable. On out_ready=1 the state goes to IDLE and out_valid drops next cycle. With out_ready=0 the state holds indefinitely.
- Latency from the accept edge:
  - Compute path: out_valid high after MANT+2 edges (12 at default).
  - Special path: 1 edge.
  - Minimum initiation interval: MANT+3 cycles compute, 2 cycles special.
- No overlap: in_ready is low in MUL and DONE, and in_valid is ignored there. The upstream holds its data; the stage-1 enable is driven from in_ready.
- Output registers change only on the accept edge (sign_out, exp_sum, spe_case_out, exp_eq_inf_out) or on the MUL→DONE transition (mant_prod). They are stable whenever out_valid=1.
- rst asserted mid-MUL or in DONE aborts the operation immediately; no stale out_valid appears after rst deasserts.
- The counter is ceil(log2(MANT+1)) bits and never exceeds MANT.

Test Plan:
- 1.0×1.0: mant_a=mant_b=0x400, exp 15/15, codes 0 → after 12 edges out_valid=1, mant_prod=0x100000, exp_sum=15, spe_case_out=0.
- Max normals: 0x7FF×0x7FF, exp 30/30, sign_in=1 → mant_prod=0x3FF001, exp_sum=45, sign_out=1.
- Denormal: mant_a=0x001 exp 1 code 1, with B=1.0 → mant_prod=0x400, exp_sum=1, spe_case_out=0.
- Specials:
  - inf×zero (codes 3,2) → spe_case_out=4, mant_prod=0, out_valid after 1 edge.
  - inf×normal → 3.
  - zero×NaN → 4.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → outputs stable, in_ready=0, a new in_valid is ignored. Then pulse out_ready → return to IDLE, next operand accepted.
- Reset mid-MUL: assert rst at cycle 5 of a multiply → all outputs 0 and in_ready=1 without waiting for a clock edge. A following 1.5×1.5 (0x600×0x600) gives mant_prod=0x240000.

Source files
------------

// File: rtl/fp_mul_stage_2.sv
// Second FP multiplier stage: resolves the special-case class, forms the biased exponent
// sum and computes the mantissa product with an iterative radix-2 shift-add multiplier.
module fp_mul_stage_2 #(
  parameter int DW   = 16,
  parameter int EXP  = 5,
  parameter int MANT = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  sign_in,
  input  logic [MANT:0]         mant_a,
  input  logic [MANT:0]         mant_b,
  input  logic [EXP-1:0]        exp_a,
  input  logic [EXP-1:0]        exp_b,
  input  logic [2:0]            spe_case_a,
  input  logic [2:0]            spe_case_b,
  input  logic                  exp_eq_inf_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sign_out,
  output logic [2*MANT+1:0]     mant_prod,
  output logic [EXP+1:0]        exp_sum,
  output logic [2:0]            spe_case_out,
  output logic                  exp_eq_inf_out
);

  localparam int              PW       = 2 * MANT + 2;
  localparam int              CW       = $clog2(MANT + 1);
  localparam logic [EXP+1:0]  BIAS     = (EXP + 2)'(2 ** (EXP - 1) - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(MANT);

  localparam logic [2:0] CODE_ZERO = 3'd2;
  localparam logic [2:0] CODE_INF  = 3'd3;
  localparam logic [2:0] CODE_NAN  = 3'd4;

  if (DW < EXP + MANT + 1) begin : g_bad_width
    $error("fp_mul_stage_2: DW too small for EXP and MANT");
  end

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   acc, acc_nxt, partial;
  logic [MANT:0]   ma_q, mb_q;
  logic [2:0]      code_res;
  logic            accept, last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CNT_LAST);

  // NaN wins over inf, inf over zero; inf*zero is itself NaN.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    code_res = 3'd0;
    if (spe_case_a == CODE_NAN || spe_case_b == CODE_NAN ||
        (spe_case_a == CODE_INF && spe_case_b == CODE_ZERO) ||
        (spe_case_a == CODE_ZERO && spe_case_b == CODE_INF))
      code_res = CODE_NAN;
    else if (spe_case_a == CODE_INF || spe_case_b == CODE_INF)
      code_res = CODE_INF;
    else if (spe_case_a == CODE_ZERO || spe_case_b == CODE_ZERO)
      code_res = CODE_ZERO;
  end

  always_comb begin
    partial = mb_q[cnt] ? ({{(PW - MANT - 1){1'b0}}, ma_q} << cnt) : '0;
    acc_nxt = acc + partial;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = (code_res == 3'd0) ? MUL : DONE;
      MUL:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      acc            <= '0;
      ma_q           <= '0;
      mb_q           <= '0;
      sign_out       <= 1'b0;
      exp_sum        <= '0;
      spe_case_out   <= 3'd0;
      exp_eq_inf_out <= 1'b0;
      mant_prod      <= '0;
    end else if (accept) begin
      cnt            <= '0;
      acc            <= '0;
      ma_q           <= mant_a;
      mb_q           <= mant_b;
      sign_out       <= sign_in;
      exp_sum        <= {2'b00, exp_a} + {2'b00, exp_b} - BIAS;
      spe_case_out   <= code_res;
      exp_eq_inf_out <= exp_eq_inf_in;
      mant_prod      <= '0;
    end else if (state == MUL) begin
      acc <= acc_nxt;
      if (last) begin
        mant_prod <= acc_nxt;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_stage_2.sv
// Self-checking bench for fp_mul_stage_2: table-driven vectors through a scoreboard queue,
// plus backpressure, reset-abort and random operand sequences.
module tb_fp_mul_stage_2;

  localparam int EXP  = 5;
  localparam int MANT = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_in = 1'b0;
  logic [10:0] mant_a = '0, mant_b = '0;
  logic [4:0]  exp_a = '0, exp_b = '0;
  logic [2:0]  spe_case_a = '0, spe_case_b = '0;
  logic        exp_eq_inf_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign_out;
  logic [21:0] mant_prod;
  logic [6:0]  exp_sum;
  logic [2:0]  spe_case_out;
  logic        exp_eq_inf_out;

  always #5 clk = ~clk;

  fp_mul_stage_2 #(.DW(16), .EXP(EXP), .MANT(MANT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .mant_a(mant_a), .mant_b(mant_b), .exp_a(exp_a), .exp_b(exp_b),
    .spe_case_a(spe_case_a), .spe_case_b(spe_case_b), .exp_eq_inf_in(exp_eq_inf_in),
    .out_valid(out_valid), .out_ready(out_ready), .sign_out(sign_out),
    .mant_prod(mant_prod), .exp_sum(exp_sum), .spe_case_out(spe_case_out),
    .exp_eq_inf_out(exp_eq_inf_out)
  );

  typedef struct {
    logic        sign;
    logic [10:0] ma, mb;
    logic [4:0]  ea, eb;
    logic [2:0]  ca, cb;
    logic        eei;
    logic [21:0] x_mant;
    logic [6:0]  x_exp;
    logic [2:0]  x_code;
    int          x_lat;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[8];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [10:0] ma, input logic [10:0] mb,
                              input logic [4:0] ea, input logic [4:0] eb,
                              input logic [2:0] ca, input logic [2:0] cb, input logic eei,
                              input logic [21:0] xm, input logic [6:0] xe, input logic [2:0] xc);
    vec_t v;
    v.sign = s; v.ma = ma; v.mb = mb; v.ea = ea; v.eb = eb;
    v.ca = ca; v.cb = cb; v.eei = eei;
    v.x_mant = xm; v.x_exp = xe; v.x_code = xc;
    v.x_lat = (xc == 3'd0) ? MANT + 2 : 1;
    return v;
  endfunction

  // Reference model for random vectors: plain arithmetic multiply and IEEE class rules.
  function automatic vec_t model(input logic s, input logic [10:0] ma, input logic [10:0] mb,
                                 input logic [4:0] ea, input logic [4:0] eb,
                                 input logic [2:0] ca, input logic [2:0] cb, input logic eei);
    logic [2:0]  c;
    int          e;
    logic [21:0] p;
    if (ca == 4 || cb == 4 || (ca == 3 && cb == 2) || (ca == 2 && cb == 3)) c = 3'd4;
    else if (ca == 3 || cb == 3) c = 3'd3;
    else if (ca == 2 || cb == 2) c = 3'd2;
    else c = 3'd0;
    e = int'(ea) + int'(eb) - 15;
    p = (c == 3'd0) ? 22'(int'(ma) * int'(mb)) : 22'd0;
    return mk(s, ma, mb, ea, eb, ca, cb, eei, p, 7'(e), c);
  endfunction

  task automatic drive(input vec_t v);
    sign_in = v.sign; mant_a = v.ma; mant_b = v.mb; exp_a = v.ea; exp_b = v.eb;
    spe_case_a = v.ca; spe_case_b = v.cb; exp_eq_inf_in = v.eei;
  endtask

  task automatic compare_out();
    vec_t e;
    check("sb_nonempty", 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("mant_prod", mant_prod, e.x_mant);
    check("exp_sum", exp_sum, e.x_exp);
    check("spe_case_out", spe_case_out, e.x_code);
    check("sign_out", sign_out, e.sign);
    check("exp_eq_inf_out", exp_eq_inf_out, e.eei);
  endtask

  // Called on a negedge; returns on a negedge with the result either released or still held.
  task automatic run_op(input vec_t v, input bit release_out);
    int waited = 0;
    int lat;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_wait", in_ready, 1);
    if (!in_ready) return;
    drive(v);
    in_valid = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, v.x_lat);
    check("in_ready_busy", in_ready, 0);
    compare_out();
    if (release_out) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("valid_drop", out_valid, 0);
      check("ready_back", in_ready, 1);
    end
  endtask

  initial begin
    vec_t v;
    bit   stale;

    tbl[0] = mk(1'b0, 11'h400, 11'h400, 5'd15, 5'd15, 3'd0, 3'd0, 1'b1, 22'h100000, 7'd15, 3'd0);
    tbl[1] = mk(1'b1, 11'h7FF, 11'h7FF, 5'd30, 5'd30, 3'd0, 3'd0, 1'b1, 22'h3FF001, 7'd45, 3'd0);
    tbl[2] = mk(1'b0, 11'h001, 11'h400, 5'd1,  5'd15, 3'd1, 3'd0, 1'b1, 22'h000400, 7'd1,  3'd0);
    tbl[3] = mk(1'b0, 11'h400, 11'h000, 5'd31, 5'd0,  3'd3, 3'd2, 1'b0, 22'h0,      7'd16, 3'd4);
    tbl[4] = mk(1'b1, 11'h400, 11'h500, 5'd31, 5'd16, 3'd3, 3'd0, 1'b0, 22'h0,      7'd32, 3'd3);
    tbl[5] = mk(1'b0, 11'h000, 11'h600, 5'd0,  5'd31, 3'd2, 3'd4, 1'b0, 22'h0,      7'd16, 3'd4);
    tbl[6] = mk(1'b0, 11'h400, 11'h400, 5'd1,  5'd1,  3'd0, 3'd0, 1'b1, 22'h100000, 7'h73, 3'd0);
    tbl[7] = mk(1'b1, 11'h500, 11'h000, 5'd10, 5'd0,  3'd0, 3'd2, 1'b1, 22'h0,      7'h7B, 3'd2);

    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_mant_prod", mant_prod, 0);
    check("rst_exp_sum", exp_sum, 0);
    check("rst_spe_case", spe_case_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_op(tbl[i], 1'b1);

    // Backpressure: result must hold while out_ready is low and new operands are ignored.
    run_op(tbl[1], 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(tbl[4]);
      in_valid = 1'b1;
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_mant", mant_prod, tbl[1].x_mant);
      check("bp_exp", exp_sum, tbl[1].x_exp);
      check("bp_code", spe_case_out, tbl[1].x_code);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    check("bp_sb_empty", sb.size(), 0);
    run_op(tbl[2], 1'b1);

    // Reset during the fifth MUL cycle must clear everything without a clock edge.
    drive(tbl[1]);
    in_valid = 1'b1;
    sb.push_back(tbl[1]);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_in_ready", in_ready, 1);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_mant", mant_prod, 0);
    check("mrst_exp", exp_sum, 0);
    check("mrst_sign", sign_out, 0);
    check("mrst_eei", exp_eq_inf_out, 0);
    void'(sb.pop_front());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("no_stale_valid", stale, 0);
    run_op(mk(1'b0, 11'h600, 11'h600, 5'd15, 5'd15, 3'd0, 3'd0, 1'b1,
              22'h240000, 7'd15, 3'd0), 1'b1);

    // Random operands, mostly on the compute path.
    for (int i = 0; i < 6; i++) begin
      logic [2:0] ca, cb;
      ca = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 4)) : 3'd0;
      cb = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 4)) : 3'd0;
      v = model(1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)),
                11'($urandom_range(0, 2047)), 5'($urandom_range(1, 30)),
                5'($urandom_range(1, 30)), ca, cb, 1'($urandom_range(0, 1)));
      run_op(v, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
